// File: rtl/shift_add_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier_if
// Brief    : Operand-issue / writeback handshake bundle for shift_add_multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_add_multiplier_if #(
    parameter int N = 64
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;

    modport master (
        output in_valid, a, b, flush, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, flush, out_ready,
        output in_ready, out_valid, product
    );
endinterface
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Brief    : Iterative unsigned N x N -> 2N shift-and-add multiplier, one
//            multiplier bit per clock through an N-bit ripple-carry adder.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int N = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_multiplier_if.slave bus
);

    localparam int            CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_mq;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_out_valid;

    logic [N-1:0]  w_add_b;
    logic [N-1:0]  w_sum;
    logic [N:0]    w_carry;
    logic          w_cout;

    // Adder operands: A = acc, B = mcand gated by the current multiplier LSB.
    assign w_add_b    = r_mq[0] ? r_mcand : '0;
    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_rca
        assign w_sum[i]     = r_acc[i] ^ w_add_b[i] ^ w_carry[i];
        assign w_carry[i+1] = (r_acc[i] & w_add_b[i]) |
                              (w_carry[i] & (r_acc[i] ^ w_add_b[i]));
    end

    assign w_cout = w_carry[N];

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = {r_acc, r_mq};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mq        <= '0;
            r_mcand     <= '0;
        end else if (bus.flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_mcand    <= bus.a;
                        r_mq       <= bus.b;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Carry-out becomes the new top bit; consumed mq LSB drops off.
                    {r_acc, r_mq} <= {w_cout, w_sum, r_mq[N-1:1]};
                    r_cnt         <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_multiplier
// Brief    : Self-checking bench: directed vectors at N=64, random streams at
//            N=8 and N=64 against an arithmetic a*b reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Index 0 drives the N=8 instance, index 1 the N=64 instance.
    logic         d_in_valid [2];
    logic         d_flush    [2];
    logic         d_out_ready[2];
    logic [63:0]  d_a        [2];
    logic [63:0]  d_b        [2];
    logic         q_in_ready [2];
    logic         q_out_valid[2];
    logic [127:0] q_product  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int W = (gi == 0) ? 8 : 64;
        shift_add_multiplier_if #(.N(W)) bus ();
        shift_add_multiplier #(.N(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign bus.in_valid    = d_in_valid[gi];
        assign bus.flush       = d_flush[gi];
        assign bus.out_ready   = d_out_ready[gi];
        assign bus.a           = d_a[gi][W-1:0];
        assign bus.b           = d_b[gi][W-1:0];
        assign q_in_ready[gi]  = bus.in_ready;
        assign q_out_valid[gi] = bus.out_valid;
        assign q_product[gi]   = 128'(bus.product);
    end

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation on the N=64 instance, with an optional output stall.
    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp, input int stall);
        int lat;
        d_a[1]         = a;
        d_b[1]         = b;
        d_in_valid[1]  = 1'b1;
        d_out_ready[1] = (stall == 0);
        chk({name, " in_ready_idle"}, 128'(q_in_ready[1]), 128'd1);
        tick();
        d_in_valid[1] = 1'b0;
        lat = 0;
        while (!q_out_valid[1] && lat < 100) begin
            tick();
            lat++;
        end
        chk({name, " latency"}, 128'(lat), 128'd64);
        chk({name, " product"}, q_product[1], exp);
        chk({name, " in_ready_done"}, 128'(q_in_ready[1]), 128'd0);
        for (int k = 0; k < stall; k++) begin
            tick();
            chk({name, " hold_valid"}, 128'(q_out_valid[1]), 128'd1);
            chk({name, " hold_product"}, q_product[1], exp);
        end
        d_out_ready[1] = 1'b1;
        tick();
        chk({name, " delivered"}, 128'(q_out_valid[1]), 128'd0);
        chk({name, " in_ready_after"}, 128'(q_in_ready[1]), 128'd1);
        d_out_ready[1] = 1'b0;
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Back-to-back stream with random output stalls, scoreboarded in order.
    task automatic run_random(input int sel, input int w, input int ops);
        logic [63:0]  mask;
        logic [127:0] q[$];
        logic [127:0] exp;
        int  issued = 0;
        int  got    = 0;
        int  cyc    = 0;
        bit  acc;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        d_in_valid[sel] = 1'b0;
        d_flush[sel]    = 1'b0;
        while (got < ops && cyc < ops * (w + 4) * 3) begin
            if (!d_in_valid[sel] && issued < ops) begin
                d_a[sel]        = rnd_operand() & mask;
                d_b[sel]        = rnd_operand() & mask;
                d_in_valid[sel] = 1'b1;
            end
            d_out_ready[sel] = ($urandom_range(0, 3) != 0);
            acc = d_in_valid[sel] && q_in_ready[sel];
            if (acc) begin
                q.push_back(128'(d_a[sel]) * 128'(d_b[sel]));
                issued++;
            end
            if (q_out_valid[sel] && d_out_ready[sel]) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rand%0d extra: product 0x%0h delivered, none expected", w, q_product[sel]);
                end else begin
                    exp = q.pop_front();
                    chk($sformatf("rand%0d product #%0d", w, got), q_product[sel], exp);
                end
                got++;
            end
            tick();
            cyc++;
            if (acc) d_in_valid[sel] = 1'b0;
        end
        d_in_valid[sel]  = 1'b0;
        d_out_ready[sel] = 1'b0;
        chk($sformatf("rand%0d delivered count", w), 128'(got), 128'(ops));
        chk($sformatf("rand%0d leftover", w), 128'(q.size()), 128'd0);
    endtask

    initial begin
        bit seen;

        vt[0] = '{64'd3, 64'd5, 128'd15};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vt[2] = '{64'd0, 64'h1234, 128'd0};
        vt[3] = '{64'd1, 64'hDEAD_BEEF_CAFE_F00D, 128'hDEAD_BEEF_CAFE_F00D};
        vt[4] = '{64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
        vt[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE};
        vt[6] = '{64'h1_2345_6789, 64'h10, 128'h12_3456_7890};
        vt[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 128'd0};

        for (int s = 0; s < 2; s++) begin
            d_in_valid[s]  = 1'b0;
            d_flush[s]     = 1'b0;
            d_out_ready[s] = 1'b0;
            d_a[s]         = '0;
            d_b[s]         = '0;
        end

        #12;
        chk("reset in_ready", 128'(q_in_ready[1]), 128'd1);
        chk("reset out_valid", 128'(q_out_valid[1]), 128'd0);
        chk("reset product", q_product[1], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset while busy, checked between clock edges.
        d_a[1] = 64'd1234;
        d_b[1] = 64'd5678;
        d_in_valid[1] = 1'b1;
        tick();
        d_in_valid[1] = 1'b0;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset in_ready", 128'(q_in_ready[1]), 128'd1);
        chk("midreset out_valid", 128'(q_out_valid[1]), 128'd0);
        chk("midreset product", q_product[1], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("post_reset", 64'd3, 64'd5, 128'd15, 0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].p, 0);

        run_op("backpressure", 64'h1_0000_0000, 64'h1_0000_0000,
               128'h1_0000_0000_0000_0000, 10);

        // Flush 20 cycles into BUSY.
        d_a[1] = 64'd9;
        d_b[1] = 64'd9;
        d_in_valid[1]  = 1'b1;
        d_out_ready[1] = 1'b1;
        tick();
        d_in_valid[1] = 1'b0;
        repeat (20) tick();
        d_flush[1] = 1'b1;
        tick();
        d_flush[1] = 1'b0;
        chk("flush_busy in_ready", 128'(q_in_ready[1]), 128'd1);
        chk("flush_busy out_valid", 128'(q_out_valid[1]), 128'd0);
        seen = 1'b0;
        repeat (80) begin
            tick();
            if (q_out_valid[1]) seen = 1'b1;
        end
        chk("flush_busy no_output", 128'(seen), 128'd0);
        run_op("after_flush", 64'd7, 64'd6, 128'd42, 0);

        // Flush wins over in_valid in IDLE.
        d_a[1] = 64'd5;
        d_b[1] = 64'd5;
        d_in_valid[1]  = 1'b1;
        d_flush[1]     = 1'b1;
        d_out_ready[1] = 1'b1;
        tick();
        d_in_valid[1] = 1'b0;
        d_flush[1]    = 1'b0;
        chk("flush_idle not_accepted", 128'(q_in_ready[1]), 128'd1);
        seen = 1'b0;
        repeat (80) begin
            tick();
            if (q_out_valid[1]) seen = 1'b1;
        end
        chk("flush_idle no_output", 128'(seen), 128'd0);
        d_out_ready[1] = 1'b0;

        fork
            run_random(0, 8, 1000);
            run_random(1, 64, 200);
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
